// File: rtl/pet_need_if.sv
// Bundles the pet need engine's control inputs and status outputs.
// The master drives the channel controls; the engine acts as the slave.
interface pet_need_if #(
    parameter int NCH   = 4,
    parameter int LVL_W = 3,
    parameter int PER_W = 16
);
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0][PER_W-1:0] period;
    logic [NCH-1:0]            recover_en;
    logic [NCH-1:0]            boost;
    logic                      load_en;
    logic [NCH-1:0][LVL_W-1:0] load_val;
    logic [NCH-1:0][LVL_W-1:0] levels;
    logic [NCH-1:0]            low_mask;
    logic [2:0]                mood;
    logic [IDX_W-1:0]          low_idx;
    logic                      mood_chg;
    logic                      tick;

    modport master (
        output period, recover_en, boost, load_en, load_val,
        input  levels, low_mask, mood, low_idx, mood_chg, tick
    );

    modport slave (
        input  period, recover_en, boost, load_en, load_val,
        output levels, low_mask, mood, low_idx, mood_chg, tick
    );
endinterface

// File: rtl/pet_need_engine.sv
// N-channel saturating need levels with per-channel decay/recover timing,
// one-shot boost, test preload and a registered mood classifier with sticky DEAD.
module pet_need_chan #(
    parameter int LVL_W   = 3,
    parameter int LVL_MAX = 5,
    parameter int PER_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             freeze,
    input  logic             load_en,
    input  logic [LVL_W-1:0] load_val,
    input  logic             boost,
    input  logic             recover_en,
    input  logic [PER_W-1:0] period,
    output logic [LVL_W-1:0] level
);
    localparam logic [LVL_W:0] MAXV = (LVL_W+1)'(LVL_MAX);

    logic [PER_W-1:0] cnt;
    logic [LVL_W:0]   up_x, dn_x, ld_x;
    logic [LVL_W-1:0] up, dn, ld;
    logic             fire;

    // One extra bit so overflow/underflow is caught before it can wrap.
    assign up_x = {1'b0, level} + 1'b1;
    assign dn_x = {1'b0, level} - 1'b1;
    assign ld_x = {1'b0, load_val};
    assign up   = (up_x > MAXV) ? MAXV[LVL_W-1:0] : up_x[LVL_W-1:0];
    assign dn   = dn_x[LVL_W] ? '0 : dn_x[LVL_W-1:0];
    assign ld   = (ld_x > MAXV) ? MAXV[LVL_W-1:0] : ld_x[LVL_W-1:0];
    assign fire = tick && (period != '0) && (cnt == period - 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            level <= MAXV[LVL_W-1:0];
            cnt   <= '0;
        end else if (load_en) begin
            level <= ld;
            cnt   <= '0;
        end else if (!freeze) begin
            if (boost) begin
                level <= up;
                cnt   <= '0;
            end else if (period == '0) begin
                cnt <= '0;
            end else if (fire) begin
                level <= recover_en ? up : dn;
                cnt   <= '0;
            end else if (tick) begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module pet_need_engine #(
    parameter int NCH      = 4,
    parameter int LVL_W    = 3,
    parameter int LVL_MAX  = 5,
    parameter int LOW_THR  = 2,
    parameter int TICK_DIV = 50000,
    parameter int PER_W    = 16
) (
    input  logic clk,
    input  logic rst,
    pet_need_if.slave bus
);
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PS_W  = $clog2(TICK_DIV);
    localparam logic [LVL_W-1:0] THR  = LVL_W'(LOW_THR);
    localparam logic [LVL_W-1:0] MAXL = LVL_W'(LVL_MAX);

    typedef enum logic [2:0] {
        M_FULL = 3'd0, M_OK = 3'd1, M_LOW = 3'd2, M_CRIT = 3'd3, M_DEAD = 3'd4
    } mood_t;

    mood_t                     mood, mood_nxt, mood_d;
    logic [NCH-1:0][LVL_W-1:0] lv;
    logic [NCH-1:0]            low_vec, low_mask;
    logic [IDX_W-1:0]          idx_nxt, low_idx;
    logic [PS_W-1:0]           presc;
    logic                      tick, load_d, dead_eff, mood_chg;
    logic                      any_zero, all_max, one_low, two_low;

    assign tick = (presc == PS_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) presc <= '0;
        else     presc <= tick ? '0 : presc + 1'b1;
    end

    // A load in the previous cycle lifts the sticky DEAD so the freshly
    // loaded levels are classified on their own merits.
    assign dead_eff = (mood == M_DEAD) && !load_d;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        pet_need_chan #(.LVL_W(LVL_W), .LVL_MAX(LVL_MAX), .PER_W(PER_W)) u_ch (
            .clk        (clk),
            .rst        (rst),
            .tick       (tick),
            .freeze     (dead_eff),
            .load_en    (bus.load_en),
            .load_val   (bus.load_val[g]),
            .boost      (bus.boost[g]),
            .recover_en (bus.recover_en[g]),
            .period     (bus.period[g]),
            .level      (lv[g])
        );
    end

    always_comb begin
        low_vec  = '0;
        idx_nxt  = '0;
        any_zero = 1'b0;
        all_max  = 1'b1;
        one_low  = 1'b0;
        two_low  = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            low_vec[i] = (lv[i] != '0) && (lv[i] <= THR);
            if (lv[i] == '0)  any_zero = 1'b1;
            if (lv[i] != MAXL) all_max = 1'b0;
            if (low_vec[i]) begin
                two_low = two_low | one_low;
                one_low = 1'b1;
                idx_nxt = IDX_W'(i);
            end
        end
        mood_nxt = M_OK;
        if (any_zero || dead_eff) mood_nxt = M_DEAD;
        else if (two_low)         mood_nxt = M_CRIT;
        else if (one_low)         mood_nxt = M_LOW;
        else if (all_max)         mood_nxt = M_FULL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mood     <= M_FULL;
            mood_d   <= M_FULL;
            low_mask <= '0;
            low_idx  <= '0;
            mood_chg <= 1'b0;
            load_d   <= 1'b0;
        end else begin
            mood     <= mood_nxt;
            mood_d   <= mood;
            low_mask <= (mood_nxt == M_DEAD) ? '0 : low_vec;
            low_idx  <= (mood_nxt == M_DEAD) ? '0 : idx_nxt;
            mood_chg <= (mood != mood_d);
            load_d   <= bus.load_en;
        end
    end

    assign bus.levels   = lv;
    assign bus.low_mask = low_mask;
    assign bus.mood     = mood;
    assign bus.low_idx  = low_idx;
    assign bus.mood_chg = mood_chg;
    assign bus.tick     = tick;
endmodule

// File: tb/tb_pet_need_engine.sv
// Directed-vector bench: stimulus queues cycle-tagged expectations,
// a negedge monitor compares each one when its cycle comes round.
module tb_pet_need_engine;
    localparam int K_LVL = 0, K_MOOD = 1, K_MASK = 2, K_IDX = 3, K_CHG = 4, K_TICK = 5;

    typedef struct {
        int    due;
        int    kind;
        int    idx;
        int    val;
        string name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    bit   done = 1'b0;
    exp_t sb[$];

    pet_need_if #(.NCH(4), .LVL_W(3), .PER_W(16)) bus ();

    pet_need_engine #(
        .NCH(4), .LVL_W(3), .LVL_MAX(5), .LOW_THR(2), .TICK_DIV(4), .PER_W(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0][2:0] pk(input int c0, input int c1, input int c2, input int c3);
        logic [3:0][2:0] r;
        r[0] = 3'(c0); r[1] = 3'(c1); r[2] = 3'(c2); r[3] = 3'(c3);
        return r;
    endfunction

    function automatic logic [3:0][15:0] pp(input int c0, input int c1, input int c2, input int c3);
        logic [3:0][15:0] r;
        r[0] = 16'(c0); r[1] = 16'(c1); r[2] = 16'(c2); r[3] = 16'(c3);
        return r;
    endfunction

    function automatic int actual(input int kind, input int idx);
        case (kind)
            K_LVL:   return int'(bus.levels[idx]);
            K_MOOD:  return int'(bus.mood);
            K_MASK:  return int'(bus.low_mask);
            K_IDX:   return int'(bus.low_idx);
            K_CHG:   return int'(bus.mood_chg);
            default: return int'(bus.tick);
        endcase
    endfunction

    task automatic ex(input int due, input int kind, input int idx, input int val, input string name);
        exp_t e;
        e.due = due; e.kind = kind; e.idx = idx; e.val = val; e.name = name;
        sb.push_back(e);
    endtask

    task automatic ex_lv4(input int due, input int v, input string name);
        for (int i = 0; i < 4; i++) ex(due, K_LVL, i, v, name);
    endtask

    task automatic ex_idle(input int due, input string name);
        ex_lv4(due, 5, name);
        ex(due, K_MOOD, 0, 0, name);
        ex(due, K_MASK, 0, 0, name);
        ex(due, K_IDX, 0, 0, name);
        ex(due, K_CHG, 0, 0, name);
        ex(due, K_TICK, 0, 0, name);
    endtask

    // Drive point: just after edge c; whatever is set here is seen at edge c+1.
    task automatic go(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
                n_vec++;
                if (sb[i].due < cyc) begin
                    n_bad++;
                    $display("FAIL %s: expectation for cycle %0d missed (now %0d)", sb[i].name, sb[i].due, cyc);
                end else if (actual(sb[i].kind, sb[i].idx) != sb[i].val) begin
                    n_bad++;
                    $display("FAIL %s @cyc %0d kind %0d ch %0d: got %0d expected %0d", sb[i].name, cyc,
                             sb[i].kind, sb[i].idx, actual(sb[i].kind, sb[i].idx), sb[i].val);
                end
                sb.delete(i);
            end
        end
        if (done || cyc > 2000) begin
            if (!done) begin
                n_bad++;
                $display("FAIL timeout: stimulus did not complete by cycle %0d", cyc);
            end
            foreach (sb[i]) begin
                n_vec++;
                n_bad++;
                $display("FAIL %s: never checked (due %0d)", sb[i].name, sb[i].due);
            end
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
            $finish;
        end
    end

    initial begin
        bus.period     = pp(3, 3, 3, 3);
        bus.recover_en = '0;
        bus.boost      = '0;
        bus.load_en    = 1'b0;
        bus.load_val   = pk(0, 0, 0, 0);

        // reset state and first decay: ticks consumed at edges 8,12,16,...
        ex_idle(4, "reset");
        ex(6, K_TICK, 0, 0, "tick_lo");
        ex(7, K_TICK, 0, 1, "tick_hi");
        ex_lv4(15, 5, "decay_before");
        ex_lv4(16, 4, "decay_third_tick");
        ex(16, K_MOOD, 0, 0, "mood_latency");
        ex(17, K_MOOD, 0, 1, "mood_ok");
        ex(17, K_CHG, 0, 0, "chg_not_yet");
        ex(18, K_CHG, 0, 1, "chg_pulse");
        ex(19, K_CHG, 0, 0, "chg_once");
        go(4);
        rst = 1'b0;

        // recover with saturation on ch0
        go(20);
        bus.period = pp(2, 0, 0, 0);
        bus.recover_en = 4'b0001;
        bus.load_val = pk(3, 5, 5, 5);
        bus.load_en = 1'b1;
        ex(21, K_LVL, 0, 3, "rec_load");
        ex(22, K_MOOD, 0, 1, "rec_mood_ok");
        ex(23, K_CHG, 0, 0, "rec_no_chg");
        ex(27, K_LVL, 0, 3, "rec_hold");
        ex(28, K_LVL, 0, 4, "rec_step1");
        ex(35, K_LVL, 0, 4, "rec_hold2");
        ex(36, K_LVL, 0, 5, "rec_step2");
        ex(45, K_LVL, 0, 5, "rec_sat");
        ex(37, K_MOOD, 0, 0, "rec_full");
        ex(38, K_CHG, 0, 1, "rec_chg");
        go(21);
        bus.load_en = 1'b0;
        go(46);
        bus.recover_en = '0;
        bus.period = pp(0, 0, 0, 0);

        // boost collides with a ch1 decay event at edge 56
        go(48);
        bus.period = pp(0, 2, 0, 0);
        bus.load_val = pk(5, 4, 5, 5);
        bus.load_en = 1'b1;
        ex(50, K_MOOD, 0, 1, "col_ok");
        ex(55, K_LVL, 1, 4, "col_before");
        ex(56, K_LVL, 1, 5, "col_boost_wins");
        ex(57, K_MOOD, 0, 0, "col_full");
        ex(63, K_LVL, 1, 5, "col_full_period");
        ex(64, K_LVL, 1, 4, "col_next_decay");
        ex(65, K_MOOD, 0, 1, "col_ok2");
        go(49);
        bus.load_en = 1'b0;
        go(55);
        bus.boost = 4'b0010;
        go(56);
        bus.boost = '0;
        go(65);
        bus.period = pp(0, 0, 0, 0);

        // classifier
        go(68);
        bus.load_val = pk(5, 2, 1, 5);
        bus.load_en = 1'b1;
        ex(69, K_LVL, 1, 2, "cls_ld1");
        ex(69, K_LVL, 2, 1, "cls_ld2");
        ex(70, K_MOOD, 0, 3, "cls_crit");
        ex(70, K_MASK, 0, 6, "cls_mask");
        ex(70, K_IDX, 0, 1, "cls_idx");
        ex(71, K_CHG, 0, 1, "cls_chg");
        go(69);
        bus.load_en = 1'b0;
        go(72);
        bus.load_val = pk(5, 5, 2, 5);
        bus.load_en = 1'b1;
        ex(73, K_MOOD, 0, 3, "cls_crit_hold");
        ex(74, K_MOOD, 0, 2, "cls_low");
        ex(74, K_MASK, 0, 4, "cls_mask2");
        ex(74, K_IDX, 0, 2, "cls_idx2");
        go(73);
        bus.load_en = 1'b0;

        // death is sticky until a load
        go(76);
        bus.period = pp(1, 0, 0, 0);
        bus.load_val = pk(1, 5, 5, 5);
        bus.load_en = 1'b1;
        ex(78, K_MOOD, 0, 2, "dead_pre_low");
        ex(78, K_MASK, 0, 1, "dead_pre_mask");
        ex(79, K_LVL, 0, 1, "dead_pre_lvl");
        ex(80, K_LVL, 0, 0, "dead_zero");
        ex(81, K_MOOD, 0, 4, "dead_mood");
        ex(81, K_MASK, 0, 0, "dead_mask_clr");
        ex(82, K_CHG, 0, 1, "dead_chg");
        ex(83, K_LVL, 0, 0, "dead_boost_ign");
        ex(90, K_LVL, 0, 0, "dead_frozen");
        ex(90, K_MOOD, 0, 4, "dead_sticky");
        go(77);
        bus.load_en = 1'b0;
        go(82);
        bus.boost = 4'b1111;
        bus.recover_en = 4'b0001;
        go(83);
        bus.boost = '0;
        go(90);
        bus.load_val = pk(5, 5, 5, 5);
        bus.recover_en = '0;
        bus.period = pp(0, 0, 0, 0);
        bus.load_en = 1'b1;
        ex(91, K_LVL, 0, 5, "revive_lvl");
        ex(91, K_MOOD, 0, 4, "revive_latency");
        ex(92, K_MOOD, 0, 0, "revive_full");
        ex(93, K_CHG, 0, 1, "revive_chg");
        go(91);
        bus.load_en = 1'b0;

        // period 0 freezes a channel across ~100 ticks, even with recover held
        go(92);
        bus.load_val = pk(5, 5, 3, 5);
        bus.recover_en = 4'b0100;
        bus.load_en = 1'b1;
        ex(94, K_MOOD, 0, 1, "p0_ok");
        ex(500, K_LVL, 2, 3, "p0_frozen");
        go(93);
        bus.load_en = 1'b0;

        // preload clamp
        go(500);
        bus.load_val = pk(7, 5, 5, 5);
        bus.recover_en = '0;
        bus.load_en = 1'b1;
        ex(501, K_LVL, 0, 5, "clamp");
        ex(501, K_LVL, 2, 5, "clamp_ch2");
        ex(502, K_MOOD, 0, 0, "clamp_full");
        go(501);
        bus.load_en = 1'b0;

        // reset mid-count restores everything including prescaler and counters
        go(504);
        bus.period = pp(3, 3, 3, 3);
        ex(516, K_LVL, 0, 4, "mid_decay");
        ex(525, K_MOOD, 0, 1, "mid_ok");
        ex_idle(526, "mid_reset");
        ex(528, K_TICK, 0, 0, "mid_tick_lo");
        ex(529, K_TICK, 0, 1, "mid_tick_hi");
        ex(537, K_LVL, 0, 5, "mid_cnt_cleared");
        ex(538, K_LVL, 0, 4, "mid_full_period");
        go(525);
        rst = 1'b1;
        go(526);
        rst = 1'b0;

        go(540);
        done = 1'b1;
    end
endmodule
